// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared types and helpers for the shared-register arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, ACK)
//   rr_pick_t   : round-robin search result (found flag + winner index)
//   rr_pick()   : first set request bit searching upward from last+1 mod n
package dff_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int MAX_IDX = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic               found;
    logic [MAX_IDX-1:0] idx;
  } rr_pick_t;

  // Requests are zero-extended to MAX_REQ so one function serves every N_REQ;
  // only the first n bits are ever looked at.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [MAX_IDX-1:0] last,
                                       input int                 n);
    rr_pick_t r;
    int       c;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        c = (int'(last) + k) % n;
        if (!r.found && req[c[MAX_IDX-1:0]]) begin
          r.found = 1'b1;
          r.idx   = c[MAX_IDX-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_bank.sv
// dff_cell: one async-clear D flip-flop with synchronous set and load enable.
//   clk, clear (async, active high), d, en (load), set (load 1), q
// dff_bank: WIDTH copies of dff_cell sharing control, holding the shared value.
//   clk, clear, load, set, d[WIDTH], q[WIDTH]
module dff_cell (
  input  logic clk,
  input  logic clear,
  input  logic d,
  input  logic en,
  input  logic set,
  output logic q
);
  // set outranks load; the arbiter never asserts both in one cycle anyway
  always_ff @(posedge clk or posedge clear) begin
    if (clear)    q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (en)  q <= d;
  end
endmodule

module dff_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             set,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    dff_cell u_bit (
      .clk  (clk),
      .clear(clear),
      .d    (d[g]),
      .en   (load),
      .set  (set),
      .q    (q[g])
    );
  end
endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin arbiter sharing one WIDTH-bit register between
// N_REQ requesters over a four-phase req/gnt/ack handshake.
//   clk, clear (async, active high)
//   req[N_REQ]          request levels, held until ack then dropped
//   wdata[N_REQ*WIDTH]  slice i is requester i's write data
//   preset              load all ones while idle
//   gnt/ack[N_REQ]      registered one-hot grant / acknowledge
//   q, q_owner, q_valid shared value, last writer, written-since-reset flag
//   busy                FSM not idle
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic               preset,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic [WIDTH-1:0]   q,
  output logic [IDX_W-1:0]   q_owner,
  output logic               q_valid,
  output logic               busy
);

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] rr_last, rr_last_n;
  logic [IDX_W-1:0] win, win_n;
  logic [N_REQ-1:0] gnt_n, ack_n;
  logic [IDX_W-1:0] owner_n;
  logic             valid_n;
  logic             bank_load, bank_set;
  logic [WIDTH-1:0] win_data;
  rr_pick_t         pick;

  always_comb pick = rr_pick(MAX_REQ'(req), MAX_IDX'(rr_last), N_REQ);

  always_comb win_data = wdata[int'(win)*WIDTH +: WIDTH];

  always_comb begin
    state_n   = state;
    rr_last_n = rr_last;
    win_n     = win;
    gnt_n     = gnt;
    ack_n     = ack;
    owner_n   = q_owner;
    valid_n   = q_valid;
    bank_load = 1'b0;
    bank_set  = 1'b0;
    case (state)
      IDLE: begin
        // preset wins over pending requests; they are picked up next cycle
        if (preset) begin
          bank_set = 1'b1;
          valid_n  = 1'b1;
        end else if (pick.found) begin
          win_n   = IDX_W'(pick.idx);
          gnt_n   = N_REQ'(1) << pick.idx;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // write completes even if the winner already dropped req
        bank_load = 1'b1;
        owner_n   = win;
        valid_n   = 1'b1;
        ack_n     = N_REQ'(1) << win;
        rr_last_n = win;
        state_n   = ACK;
      end
      ACK: begin
        if (!req[win]) begin
          gnt_n   = '0;
          ack_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        gnt_n   = '0;
        ack_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_n;
  end

  // rr_last resets to the top index so requester 0 is searched first
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      rr_last <= IDX_W'(N_REQ-1);
      win     <= '0;
      gnt     <= '0;
      ack     <= '0;
      q_owner <= '0;
      q_valid <= 1'b0;
    end else begin
      rr_last <= rr_last_n;
      win     <= win_n;
      gnt     <= gnt_n;
      ack     <= ack_n;
      q_owner <= owner_n;
      q_valid <= valid_n;
    end
  end

  dff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk  (clk),
    .clear(clear),
    .load (bank_load),
    .set  (bank_set),
    .d    (win_data),
    .q    (q)
  );

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter: directed + randomized handshake transactions checked
// against a transaction-level model (round-robin pointer, stored value).
module tb_dff_reg_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             clear;
  logic [N-1:0]     req;
  logic [N*W-1:0]   wdata;
  logic             preset;
  logic [N-1:0]     gnt, ack;
  logic [W-1:0]     q;
  logic [IW-1:0]    q_owner;
  logic             q_valid, busy;

  dff_reg_arbiter #(.N_REQ(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .clear(clear), .req(req), .wdata(wdata), .preset(preset),
    .gnt(gnt), .ack(ack), .q(q), .q_owner(q_owner), .q_valid(q_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int           m_last;
  logic [W-1:0] m_q;
  int           m_owner;
  logic         m_valid;
  logic [W-1:0] tdata [N];
  logic [N-1:0] resid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pack_wdata;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = tdata[i];
  endtask

  task automatic scramble_wdata;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = W'($urandom);
  endtask

  // next winner: first requester after the last winner, wrapping around
  function automatic int model_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_reset;
    m_last = N-1; m_q = '0; m_owner = 0; m_valid = 1'b0; resid = '0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    #2;
    chk("clr_q", 32'(q), 32'h0);
    chk("clr_gnt", 32'(gnt), 32'h0);
    chk("clr_ack", 32'(ack), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_valid", 32'(q_valid), 32'h0);
    chk("clr_owner", 32'(q_owner), 32'h0);
    req = '0;
    tick;
    clear = 1'b0;
    model_reset();
  endtask

  // One full handshake starting in idle. hold<0: winner drops req while the
  // write is in flight. preset_ack: preset raised during ACK and kept one
  // idle cycle beyond.
  task automatic do_txn(input logic [N-1:0] mask, input int hold, input bit preset_ack);
    int w;
    logic [N-1:0] oh;
    w  = model_pick(mask, m_last);
    oh = N'(1) << w;
    req = mask;
    pack_wdata();
    tick;
    chk("gnt_e1", 32'(gnt), 32'(oh));
    chk("ack_e1", 32'(ack), 32'h0);
    chk("busy_e1", 32'(busy), 32'h1);
    chk("q_e1", 32'(q), 32'(m_q));
    if (hold < 0) req[w] = 1'b0;
    tick;
    m_q = tdata[w]; m_owner = w; m_valid = 1'b1; m_last = w;
    chk("q_e2", 32'(q), 32'(m_q));
    chk("owner_e2", 32'(q_owner), 32'(m_owner));
    chk("valid_e2", 32'(q_valid), 32'h1);
    chk("ack_e2", 32'(ack), 32'(oh));
    chk("gnt_e2", 32'(gnt), 32'(oh));
    scramble_wdata();
    if (preset_ack) preset = 1'b1;
    for (int c = 0; c < hold; c++) begin
      tick;
      chk("gnt_hold", 32'(gnt), 32'(oh));
      chk("ack_hold", 32'(ack), 32'(oh));
      chk("q_hold", 32'(q), 32'(m_q));
      chk("busy_hold", 32'(busy), 32'h1);
    end
    req[w] = 1'b0;
    resid  = req;
    tick;
    chk("gnt_rel", 32'(gnt), 32'h0);
    chk("ack_rel", 32'(ack), 32'h0);
    chk("busy_rel", 32'(busy), 32'h0);
    chk("q_rel", 32'(q), 32'(m_q));
    if (preset_ack) begin
      tick;
      m_q = '1; m_valid = 1'b1;
      chk("q_preset_late", 32'(q), 32'(m_q));
      chk("gnt_preset_late", 32'(gnt), 32'h0);
      chk("busy_preset_late", 32'(busy), 32'h0);
      preset = 1'b0;
    end
  endtask

  task automatic do_preset(input logic [N-1:0] mask);
    preset = 1'b1;
    req    = mask;
    tick;
    m_q = '1; m_valid = 1'b1;
    chk("q_preset", 32'(q), 32'(m_q));
    chk("owner_preset", 32'(q_owner), 32'(m_owner));
    chk("valid_preset", 32'(q_valid), 32'h1);
    chk("gnt_preset", 32'(gnt), 32'h0);
    chk("busy_preset", 32'(busy), 32'h0);
    preset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] mask;
    clear = 1'b1; req = '0; preset = 1'b0; wdata = '0;
    for (int i = 0; i < N; i++) tdata[i] = '0;
    model_reset();
    tick;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_valid", 32'(q_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    clear = 1'b0;

    // clear in the middle of ACK with 0x5A stored
    tdata[0] = 8'h5A;
    req = 4'b0001;
    pack_wdata();
    tick;
    tick;
    chk("q_5a", 32'(q), 32'h5A);
    chk("ack_5a", 32'(ack), 32'h1);
    do_clear();
    for (int i = 0; i < N; i++) tdata[i] = W'($urandom);
    do_txn(4'b1111, 1, 1'b0);

    // single requester 2
    tdata[2] = 8'hC3;
    do_txn(4'b0100, 0, 1'b0);

    // full rotation 0,1,2,3,0 with everyone requesting
    do_clear();
    tdata[0] = 8'h11; tdata[1] = 8'h22; tdata[2] = 8'h33; tdata[3] = 8'h44;
    do_txn(4'b1111, 0, 1'b0);
    do_txn(resid, 0, 1'b0);
    do_txn(resid, 0, 1'b0);
    do_txn(resid, 0, 1'b0);
    do_txn(4'b1111, 0, 1'b0);

    // preset collides with a request in idle, then request is served
    do_preset(4'b0001);
    do_txn(4'b0001, 0, 1'b0);

    // preset arrives during ACK, takes effect only after release
    tdata[1] = 8'h96;
    do_txn(4'b0010, 2, 1'b1);

    // requester 1 lingers in ACK while 3 waits
    do_clear();
    do_txn(4'b1010, 10, 1'b0);
    do_txn(resid, 0, 1'b0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      mask = resid | N'($urandom_range(0, 15));
      if (mask == '0) mask = 4'b0001;
      for (int i = 0; i < N; i++) tdata[i] = W'($urandom);
      if ($urandom_range(0, 3) == 0) do_preset(mask);
      do_txn(mask, int'($urandom_range(0, 4)) - 1, $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
